// File: rtl/debug_tx_framer.sv
// Debug unit transmit framer: snapshots PC, cycle count, register file
// and data memory, then streams them LSB-first behind a header byte.
module debug_tx_framer #(
  parameter int          NUM_REGS = 32,
  parameter int          NUM_MEM  = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_cycles,
  input  logic [31:0]       i_rd_data,
  input  logic              i_tx_done,
  output logic              o_rd_sel,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [7:0]        o_data_send,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_done
);

  localparam int TOTAL = 2 + NUM_REGS + NUM_MEM;
  localparam int IW    = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT, LOAD, CAPTURE, DONE
  } state_t;

  state_t          state;
  logic [31:0]     pc_snap;
  logic [31:0]     cyc_snap;
  logic [31:0]     word;
  logic [1:0]      byte_cnt;
  logic            hdr;
  logic [IW-1:0]   word_idx;
  logic [IW-1:0]   off;
  logic [IW-1:0]   moff;
  logic            is_mem;
  logic            word_end;
  logic            last_word;

  assign off       = word_idx - IW'(2);
  assign moff      = off - IW'(NUM_REGS);
  assign is_mem    = word_idx >= IW'(2 + NUM_REGS);
  assign word_end  = hdr || (byte_cnt == 2'd3);
  assign last_word = word_idx == IW'(TOTAL);

  assign o_data_send = word[7:0];

  // word_idx names the next word to fetch; the read port is set up on
  // entry to LOAD so the registered read data is ready in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_snap    <= '0;
      cyc_snap   <= '0;
      word       <= '0;
      byte_cnt   <= '0;
      hdr        <= 1'b0;
      word_idx   <= '0;
      o_rd_sel   <= 1'b0;
      o_rd_addr  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            pc_snap    <= i_pc;
            cyc_snap   <= i_cycles;
            word       <= {24'd0, HEADER};
            hdr        <= 1'b1;
            byte_cnt   <= '0;
            word_idx   <= '0;
            o_busy     <= 1'b1;
            o_tx_start <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (i_tx_done) begin
            if (!word_end) begin
              word       <= word >> 8;
              byte_cnt   <= byte_cnt + 2'd1;
              o_tx_start <= 1'b1;
              state      <= SEND;
            end else if (last_word) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              if (word_idx >= IW'(2)) begin
                o_rd_sel  <= is_mem;
                o_rd_addr <= is_mem ? ADDR_W'(moff) : ADDR_W'(off);
              end
              state <= LOAD;
            end
          end
        end
        LOAD: state <= CAPTURE;
        CAPTURE: begin
          if (word_idx == IW'(0))
            word <= pc_snap;
          else if (word_idx == IW'(1))
            word <= cyc_snap;
          else
            word <= i_rd_data;
          hdr        <= 1'b0;
          byte_cnt   <= '0;
          word_idx   <= word_idx + IW'(1);
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_framer.sv
// Directed bench for debug_tx_framer: two parameterisations, a UART tx
// responder with adjustable gaps, and register/memory read models.
module tb_debug_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st = 1'b0;
  logic        tx_done = 1'b0;
  logic [31:0] pc = 32'h40;
  logic [31:0] cyc = 32'h12345678;
  int          cur = 0;

  logic        a_start, a_sel, a_txs, a_busy, a_done;
  logic [4:0]  a_addr;
  logic [7:0]  a_data;
  logic [31:0] a_rd = '0;
  logic        b_start, b_sel, b_txs, b_busy, b_done;
  logic [4:0]  b_addr;
  logic [7:0]  b_data;
  logic [31:0] b_rd = '0;

  int tests = 0;
  int fails = 0;
  int a_dc = 0;
  int b_dc = 0;
  bit b_sel_seen = 1'b0;

  logic [7:0] exp_tab [2][21];

  always #5 clk = ~clk;

  assign a_start = st && (cur == 0);
  assign b_start = st && (cur == 1);

  debug_tx_framer #(.NUM_REGS(2), .NUM_MEM(1), .ADDR_W(5)) ua (
    .clk(clk), .rst(rst), .i_start(a_start), .i_pc(pc),
    .i_cycles(cyc), .i_rd_data(a_rd), .i_tx_done(tx_done),
    .o_rd_sel(a_sel), .o_rd_addr(a_addr), .o_data_send(a_data),
    .o_tx_start(a_txs), .o_busy(a_busy), .o_done(a_done));

  debug_tx_framer #(.NUM_REGS(1), .NUM_MEM(0), .ADDR_W(5)) ub (
    .clk(clk), .rst(rst), .i_start(b_start), .i_pc(pc),
    .i_cycles(cyc), .i_rd_data(b_rd), .i_tx_done(tx_done),
    .o_rd_sel(b_sel), .o_rd_addr(b_addr), .o_data_send(b_data),
    .o_tx_start(b_txs), .o_busy(b_busy), .o_done(b_done));

  // Debug read ports answer one cycle after the address is presented.
  always_ff @(posedge clk) begin
    a_rd <= a_sel ? (a_addr == 5'd0 ? 32'hCAFEBABE : 32'hBAD0BAD0)
                  : (a_addr == 5'd0 ? 32'h11111111
                  :  a_addr == 5'd1 ? 32'hDEADBEEF : 32'hBAD1BAD1);
    b_rd <= b_sel ? 32'hBAD2BAD2
                  : (b_addr == 5'd0 ? 32'h11111111 : 32'hBAD3BAD3);
    if (a_done) a_dc <= a_dc + 1;
    if (b_done) b_dc <= b_dc + 1;
    if (b_sel)  b_sel_seen <= 1'b1;
  end

  logic       txs, busy, done, sel;
  logic [7:0] data;
  logic [4:0] addr;
  assign txs  = cur == 1 ? b_txs  : a_txs;
  assign busy = cur == 1 ? b_busy : a_busy;
  assign done = cur == 1 ? b_done : a_done;
  assign sel  = cur == 1 ? b_sel  : a_sel;
  assign data = cur == 1 ? b_data : a_data;
  assign addr = cur == 1 ? b_addr : a_addr;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_frame(input int w, input int n, input int poke,
                           input int stall, input int abort,
                           input int spur);
    int k;
    int g;
    bit ok;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        tick();
        tx_done = 1'b0;
        st = 1'b0;
        k++;
      end while (!txs && k < 20);
      if (!txs) begin
        check("tx_start_timeout", 32'(k), 32'(0));
        return;
      end
      check("latency", 32'(k), (i % 4 == 1) ? 32'd3 : 32'd1);
      check("byte", {24'd0, data}, {24'd0, exp_tab[w][i]});
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      if (i == abort) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs",
              {16'd0, txs, busy, done, sel, data, 3'd0, addr},
              32'd0);
        return;
      end
      if (i == spur) tx_done = 1'b1;
      d  = data;
      ok = 1'b1;
      g  = (i == stall) ? 200 : 5;
      for (int c = 0; c < g; c++) begin
        tick();
        tx_done = 1'b0;
        st = 1'b0;
        if (txs || data !== d) ok = 1'b0;
        if (i == poke && c == 1) begin
          pc = 32'h80;
          st = 1'b1;
        end
      end
      st = 1'b0;
      check("hold_while_waiting", {31'd0, ok}, 32'd1);
      tx_done = 1'b1;
    end
    tick();
    tx_done = 1'b0;
    check("done_pulse", {30'd0, done, busy}, 32'b10);
    st = 1'b1;
    tick();
    st = 1'b0;
    check("done_cleared", {30'd0, done, busy}, 32'b00);
    tick();
    check("no_restart_from_done", {30'd0, txs, busy}, 32'b00);
  endtask

  initial begin
    exp_tab[0] = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56,
                   8'h34, 8'h12, 8'h11, 8'h11, 8'h11, 8'h11, 8'hEF,
                   8'hBE, 8'hAD, 8'hDE, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
    exp_tab[1] = '{8'hA5, 8'h40, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56,
                   8'h34, 8'h12, 8'h11, 8'h11, 8'h11, 8'h11, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_a", {16'd0, a_txs, a_busy, a_done, a_sel,
                      a_data, 3'd0, a_addr}, 32'd0);
    check("reset_b", {16'd0, b_txs, b_busy, b_done, b_sel,
                      b_data, 3'd0, b_addr}, 32'd0);

    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("idle_spurious_done", {30'd0, a_txs, a_busy}, 32'd0);

    cur = 0;
    st = 1'b1;
    tx_done = 1'b1;
    run_frame(0, 21, -1, -1, -1, 3);
    check("frame1_done_count", 32'(a_dc), 32'd1);

    st = 1'b1;
    run_frame(0, 21, 9, 6, -1, -1);
    check("frame2_done_count", 32'(a_dc), 32'd2);
    pc = 32'h40;

    st = 1'b1;
    run_frame(0, 21, -1, -1, 7, -1);
    repeat (10) tick();
    check("abort_no_done", 32'(a_dc), 32'd2);
    check("abort_idle", {30'd0, a_txs, a_busy}, 32'd0);
    st = 1'b1;
    run_frame(0, 21, -1, -1, -1, -1);
    check("after_abort_done_count", 32'(a_dc), 32'd3);

    cur = 1;
    st = 1'b1;
    run_frame(1, 13, -1, -1, -1, 2);
    check("small_done_count", 32'(b_dc), 32'd1);
    check("small_no_mem_sel", {31'd0, b_sel_seen}, 32'd0);
    check("a_quiet", 32'(a_dc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
